// File: rtl/sdspi_blk_seq_if.sv
// Bus bundle for sdspi_blk_seq: request/completion handshake, SD-SPI register
// master and classic Wishbone memory master.
interface sdspi_blk_seq_if #(
  parameter int unsigned MAW = 28
);
  logic           i_req_valid;
  logic           o_req_ready;
  logic           i_req_write;
  logic [31:0]    i_req_sector;
  logic [MAW-1:0] i_req_addr;
  logic [7:0]     i_req_nblk;
  logic           o_done;
  logic           o_err;
  logic [2:0]     o_err_code;

  logic           o_sd_cyc;
  logic           o_sd_stb;
  logic           o_sd_we;
  logic [2:0]     o_sd_addr;
  logic [31:0]    o_sd_data;
  logic           i_sd_ack;
  logic [31:0]    i_sd_data;

  logic           o_mem_cyc;
  logic           o_mem_stb;
  logic           o_mem_we;
  logic [MAW-1:0] o_mem_addr;
  logic [31:0]    o_mem_data;
  logic [3:0]     o_mem_sel;
  logic           i_mem_ack;
  logic           i_mem_err;
  logic [31:0]    i_mem_data;

  modport master (
    input  i_req_valid, i_req_write, i_req_sector, i_req_addr, i_req_nblk,
    input  i_sd_ack, i_sd_data, i_mem_ack, i_mem_err, i_mem_data,
    output o_req_ready, o_done, o_err, o_err_code,
    output o_sd_cyc, o_sd_stb, o_sd_we, o_sd_addr, o_sd_data,
    output o_mem_cyc, o_mem_stb, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel
  );

  modport slave (
    output i_req_valid, i_req_write, i_req_sector, i_req_addr, i_req_nblk,
    output i_sd_ack, i_sd_data, i_mem_ack, i_mem_err, i_mem_data,
    input  o_req_ready, o_done, o_err, o_err_code,
    input  o_sd_cyc, o_sd_stb, o_sd_we, o_sd_addr, o_sd_data,
    input  o_mem_cyc, o_mem_stb, o_mem_we, o_mem_addr, o_mem_data, o_mem_sel
  );
endinterface

// File: rtl/sdspi_blk_seq.sv
// Sector block-transfer sequencer driving the SD-SPI register port and a memory
// master. Define SDSPI_SEQ_TIMEOUT_EN to bound status polling (error code 4).
module sdspi_blk_seq #(
  parameter int unsigned MAW        = 28,
  parameter logic [23:0] POLL_LIMIT = 24'd16000000
) (
  input  logic            i_clk,
  input  logic            i_reset,
  sdspi_blk_seq_if.master bus
);

`ifdef SDSPI_SEQ_TIMEOUT_EN
  localparam bit TIMEOUT_EN = 1'b1;
`else
  localparam bit TIMEOUT_EN = 1'b0;
`endif

  localparam logic [2:0]  ADDR_CMD  = 3'd0;
  localparam logic [2:0]  ADDR_DAT  = 3'd1;
  localparam logic [2:0]  ADDR_FIFO = 3'd2;
  localparam logic [31:0] CMD_RD    = 32'h0000_8851;
  localparam logic [31:0] CMD_WR    = 32'h0000_8C58;
  localparam logic [4:0]  RESP_OK   = 5'b00101;
  localparam logic [2:0]  ERR_OK    = 3'd0;
  localparam logic [2:0]  ERR_CMD   = 3'd1;
  localparam logic [2:0]  ERR_TOK   = 3'd2;
  localparam logic [2:0]  ERR_MEM   = 3'd3;
  localparam logic [2:0]  ERR_TO    = 3'd4;

  typedef enum logic [3:0] {
    S_IDLE, S_ARG, S_CMD, S_POLL, S_FRST, S_FIFO_RD, S_MEM_WR,
    S_MEM_RD, S_FIFO_WR, S_RESP, S_NEXT, S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic           write_q, write_d;
  logic [31:0]    sector_q, sector_d;
  logic [MAW-1:0] mem_addr_q, mem_addr_d;
  logic [7:0]     blocks_q, blocks_d;
  logic [6:0]     word_q, word_d;
  logic [31:0]    data_q, data_d;
  logic           stat_err_q, stat_err_d;
  logic [23:0]    poll_cnt_q, poll_cnt_d;
  logic           ready_q, ready_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic [2:0]     code_q, code_d;
  logic           sd_cyc_q, sd_cyc_d;
  logic           sd_we_q, sd_we_d;
  logic [2:0]     sd_addr_q, sd_addr_d;
  logic [31:0]    sd_data_q, sd_data_d;
  logic           mem_cyc_q, mem_cyc_d;
  logic           mem_we_q, mem_we_d;

  logic           sd_ack_c;
  logic           mem_ack_c;
  logic           mem_err_c;
  logic [23:0]    poll_dec_c;

  assign bus.o_req_ready = ready_q;
  assign bus.o_done      = done_q;
  assign bus.o_err       = err_q;
  assign bus.o_err_code  = code_q;
  assign bus.o_sd_cyc    = sd_cyc_q;
  assign bus.o_sd_stb    = sd_cyc_q;
  assign bus.o_sd_we     = sd_we_q;
  assign bus.o_sd_addr   = sd_addr_q;
  assign bus.o_sd_data   = sd_data_q;
  assign bus.o_mem_cyc   = mem_cyc_q;
  assign bus.o_mem_stb   = mem_cyc_q;
  assign bus.o_mem_we    = mem_we_q;
  assign bus.o_mem_addr  = mem_addr_q;
  assign bus.o_mem_data  = data_q;
  assign bus.o_mem_sel   = 4'hf;

  // Every bus state issues when its bus is idle and advances on the ack; the
  // ack clears cyc, which forces one idle cycle before the next transaction.
  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    sector_d   = sector_q;
    mem_addr_d = mem_addr_q;
    blocks_d   = blocks_q;
    word_d     = word_q;
    data_d     = data_q;
    stat_err_d = stat_err_q;
    poll_cnt_d = poll_cnt_q;
    done_d     = 1'b0;
    err_d      = err_q;
    code_d     = code_q;
    sd_cyc_d   = sd_cyc_q;
    sd_we_d    = sd_we_q;
    sd_addr_d  = sd_addr_q;
    sd_data_d  = sd_data_q;
    mem_cyc_d  = mem_cyc_q;
    mem_we_d   = mem_we_q;

    sd_ack_c   = sd_cyc_q && bus.i_sd_ack;
    mem_err_c  = mem_cyc_q && bus.i_mem_err;
    mem_ack_c  = mem_cyc_q && bus.i_mem_ack && !bus.i_mem_err;
    poll_dec_c = poll_cnt_q - 24'(1);

    if (sd_ack_c)  sd_cyc_d  = 1'b0;
    if (mem_ack_c) mem_cyc_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (bus.i_req_valid && ready_q) begin
          write_d    = bus.i_req_write;
          sector_d   = bus.i_req_sector;
          mem_addr_d = bus.i_req_addr;
          blocks_d   = bus.i_req_nblk;
          word_d     = 7'd0;
          err_d      = 1'b0;
          code_d     = ERR_OK;
          state_d    = bus.i_req_write ? S_FRST : S_ARG;
        end
      end

      S_ARG: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b1;
          sd_addr_d = ADDR_DAT;
          sd_data_d = sector_q;
        end
        if (sd_ack_c) state_d = S_CMD;
      end

      S_CMD: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b1;
          sd_addr_d = ADDR_CMD;
          sd_data_d = write_q ? CMD_WR : CMD_RD;
        end
        if (sd_ack_c) begin
          poll_cnt_d = POLL_LIMIT;
          state_d    = S_POLL;
        end
      end

      S_POLL: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b0;
          sd_addr_d = ADDR_CMD;
        end
        if (sd_ack_c) begin
          poll_cnt_d = poll_dec_c;
          if (bus.i_sd_data[14]) begin
            if (TIMEOUT_EN && poll_dec_c == 24'd0) begin
              done_d  = 1'b1;
              err_d   = 1'b1;
              code_d  = ERR_TO;
              state_d = S_DONE;
            end
          end else if (write_q) begin
            stat_err_d = bus.i_sd_data[15];
            state_d    = S_RESP;
          end else if (bus.i_sd_data[15]) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = ERR_CMD;
            state_d = S_DONE;
          end else begin
            state_d = S_FRST;
          end
        end
      end

      S_FRST: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b1;
          sd_addr_d = ADDR_CMD;
          sd_data_d = 32'd0;
        end
        if (sd_ack_c) begin
          word_d  = 7'd0;
          state_d = write_q ? S_MEM_RD : S_FIFO_RD;
        end
      end

      S_FIFO_RD: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b0;
          sd_addr_d = ADDR_FIFO;
        end
        if (sd_ack_c) begin
          data_d  = bus.i_sd_data;
          state_d = S_MEM_WR;
        end
      end

      S_MEM_WR: begin
        if (!mem_cyc_q) begin
          mem_cyc_d = 1'b1;
          mem_we_d  = 1'b1;
        end
        if (mem_ack_c) begin
          mem_addr_d = mem_addr_q + MAW'(1);
          word_d     = word_q + 7'(1);
          state_d    = (word_q == 7'd127) ? S_NEXT : S_FIFO_RD;
        end
      end

      S_MEM_RD: begin
        if (!mem_cyc_q) begin
          mem_cyc_d = 1'b1;
          mem_we_d  = 1'b0;
        end
        if (mem_ack_c) begin
          data_d     = bus.i_mem_data;
          mem_addr_d = mem_addr_q + MAW'(1);
          state_d    = S_FIFO_WR;
        end
      end

      S_FIFO_WR: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b1;
          sd_addr_d = ADDR_FIFO;
          sd_data_d = data_q;
        end
        if (sd_ack_c) begin
          word_d  = word_q + 7'(1);
          state_d = (word_q == 7'd127) ? S_ARG : S_MEM_RD;
        end
      end

      S_RESP: begin
        if (!sd_cyc_q) begin
          sd_cyc_d  = 1'b1;
          sd_we_d   = 1'b0;
          sd_addr_d = ADDR_DAT;
        end
        if (sd_ack_c) begin
          if (stat_err_q || bus.i_sd_data[4:0] != RESP_OK) begin
            done_d  = 1'b1;
            err_d   = 1'b1;
            code_d  = stat_err_q ? ERR_CMD : ERR_TOK;
            state_d = S_DONE;
          end else begin
            state_d = S_NEXT;
          end
        end
      end

      S_NEXT: begin
        if (blocks_q == 8'd0) begin
          done_d  = 1'b1;
          err_d   = 1'b0;
          code_d  = ERR_OK;
          state_d = S_DONE;
        end else begin
          sector_d = sector_q + 32'(1);
          blocks_d = blocks_q - 8'(1);
          state_d  = write_q ? S_FRST : S_ARG;
        end
      end

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase

    // A memory bus error aborts at once; the controller is left alone.
    if (mem_err_c) begin
      mem_cyc_d = 1'b0;
      done_d    = 1'b1;
      err_d     = 1'b1;
      code_d    = ERR_MEM;
      state_d   = S_DONE;
    end

    ready_d = (state_d == S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      write_q    <= 1'b0;
      sector_q   <= 32'd0;
      mem_addr_q <= '0;
      blocks_q   <= 8'd0;
      word_q     <= 7'd0;
      data_q     <= 32'd0;
      stat_err_q <= 1'b0;
      poll_cnt_q <= 24'd0;
      ready_q    <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      code_q     <= ERR_OK;
      sd_cyc_q   <= 1'b0;
      sd_we_q    <= 1'b0;
      sd_addr_q  <= 3'd0;
      sd_data_q  <= 32'd0;
      mem_cyc_q  <= 1'b0;
      mem_we_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      sector_q   <= sector_d;
      mem_addr_q <= mem_addr_d;
      blocks_q   <= blocks_d;
      word_q     <= word_d;
      data_q     <= data_d;
      stat_err_q <= stat_err_d;
      poll_cnt_q <= poll_cnt_d;
      ready_q    <= ready_d;
      done_q     <= done_d;
      err_q      <= err_d;
      code_q     <= code_d;
      sd_cyc_q   <= sd_cyc_d;
      sd_we_q    <= sd_we_d;
      sd_addr_q  <= sd_addr_d;
      sd_data_q  <= sd_data_d;
      mem_cyc_q  <= mem_cyc_d;
      mem_we_q   <= mem_we_d;
    end
  end

endmodule

// File: tb/tb_sdspi_blk_seq.sv
// Directed bench for sdspi_blk_seq with an SD-SPI register model and a memory
// model; expected values are written by hand from the transfer protocol.
module tb_sdspi_blk_seq;
  localparam int unsigned MAW = 28;
`ifdef SDSPI_SEQ_TIMEOUT_EN
  localparam logic [23:0] PL = 24'd5;
`else
  localparam logic [23:0] PL = 24'd16000000;
`endif

  logic clk = 1'b0;
  logic rst;
  logic clr;
  always #5 clk = ~clk;

  sdspi_blk_seq_if #(.MAW(MAW)) bus ();

  sdspi_blk_seq #(.MAW(MAW), .POLL_LIMIT(PL)) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [31:0] fifo_pat(input int k);
    return 32'hA5A5_0000 ^ 32'(k);
  endfunction

  function automatic logic [31:0] mem_pat(input logic [MAW-1:0] a);
    return 32'h5A00_0000 ^ {4'h0, a};
  endfunction

  // model configuration, written by the stimulus only
  int          busy_polls;
  bit          busy_forever;
  logic [31:0] final_status;
  logic [31:0] resp_val;
  int          err_at;
  logic [MAW-1:0] mem_base;

  // controller model observations
  int          poll_cnt, status_reads, fifo_rd_cnt, fifo_wr_cnt, fifo_bad;
  int          dat_cnt, cmd_rd_cnt, cmd_wr_cnt, frst_cnt, resp_cnt, sd_after_err, wr_n;
  logic [31:0] dat_log [4];
  logic [34:0] wr_log  [4];

  // memory model observations
  int          mem_wr_cnt, mem_rd_cnt, mem_bad;
  bit          mem_err_seen;

  // monitor observations
  int          done_cnt, done_long;
  bit          done_prev, err_prev;
  logic        err_next_cyc;

  always @(posedge clk) begin
    bus.i_sd_ack <= 1'b0;
    if (rst || clr) begin
      if (clr) begin
        poll_cnt = 0; status_reads = 0; fifo_rd_cnt = 0; fifo_wr_cnt = 0; fifo_bad = 0;
        dat_cnt = 0; cmd_rd_cnt = 0; cmd_wr_cnt = 0; frst_cnt = 0; resp_cnt = 0;
        sd_after_err = 0; wr_n = 0;
      end
      bus.i_sd_data <= 32'd0;
    end else if (bus.o_sd_cyc && bus.o_sd_stb && !bus.i_sd_ack) begin
      bus.i_sd_ack <= 1'b1;
      if (mem_err_seen) sd_after_err++;
      if (bus.o_sd_we) begin
        if (wr_n < 4) wr_log[wr_n] = {bus.o_sd_addr, bus.o_sd_data};
        wr_n++;
        case (bus.o_sd_addr)
          3'd0: begin
            if (bus.o_sd_data == 32'h8851) cmd_rd_cnt++;
            else if (bus.o_sd_data == 32'h8C58) cmd_wr_cnt++;
            else if (bus.o_sd_data == 32'h0) frst_cnt++;
            poll_cnt = 0;
          end
          3'd1: begin
            if (dat_cnt < 4) dat_log[dat_cnt] = bus.o_sd_data;
            dat_cnt++;
          end
          3'd2: begin
            if (bus.o_sd_data != mem_pat(mem_base + MAW'(fifo_wr_cnt))) fifo_bad++;
            fifo_wr_cnt++;
          end
          default: ;
        endcase
      end else begin
        case (bus.o_sd_addr)
          3'd0: begin
            poll_cnt++;
            status_reads++;
            bus.i_sd_data <= (busy_forever || poll_cnt <= busy_polls) ? 32'h4000 : final_status;
          end
          3'd1: begin
            resp_cnt++;
            bus.i_sd_data <= resp_val;
          end
          3'd2: begin
            bus.i_sd_data <= fifo_pat(fifo_rd_cnt);
            fifo_rd_cnt++;
          end
          default: bus.i_sd_data <= 32'd0;
        endcase
      end
    end
  end

  always @(posedge clk) begin
    bus.i_mem_ack <= 1'b0;
    bus.i_mem_err <= 1'b0;
    if (rst || clr) begin
      if (clr) begin
        mem_wr_cnt = 0; mem_rd_cnt = 0; mem_bad = 0; mem_err_seen = 1'b0;
      end
      bus.i_mem_data <= 32'd0;
    end else if (bus.o_mem_cyc && bus.o_mem_stb && !bus.i_mem_ack && !bus.i_mem_err) begin
      if (bus.o_mem_we) begin
        if (mem_wr_cnt == err_at) begin
          bus.i_mem_err <= 1'b1;
          mem_err_seen = 1'b1;
        end else begin
          bus.i_mem_ack <= 1'b1;
          if (bus.o_mem_addr != mem_base + MAW'(mem_wr_cnt) ||
              bus.o_mem_data != fifo_pat(mem_wr_cnt) || bus.o_mem_sel != 4'hf) mem_bad++;
          mem_wr_cnt++;
        end
      end else begin
        bus.i_mem_ack  <= 1'b1;
        bus.i_mem_data <= mem_pat(bus.o_mem_addr);
        if (bus.o_mem_addr != mem_base + MAW'(mem_rd_cnt)) mem_bad++;
        mem_rd_cnt++;
      end
    end
  end

  // done pulse width and the memory cycle one clock after a bus error
  always @(posedge clk) begin
    if (clr) begin
      err_next_cyc = 1'b1;
      err_prev     = 1'b0;
    end else begin
      if (err_prev) err_next_cyc = bus.o_mem_cyc;
      err_prev = bus.i_mem_err;
    end
    if (bus.o_done) done_cnt++;
    if (bus.o_done && done_prev) done_long++;
    done_prev = bus.o_done;
  end

  logic       got_err;
  logic [2:0] got_code;

  task automatic start_req(input bit wr, input logic [31:0] sec,
                           input logic [MAW-1:0] addr, input logic [7:0] nblk);
    @(negedge clk);
    mem_base = addr;
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    bus.i_req_valid  = 1'b1;
    bus.i_req_write  = wr;
    bus.i_req_sector = sec;
    bus.i_req_addr   = addr;
    bus.i_req_nblk   = nblk;
    @(negedge clk);
    bus.i_req_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 20000 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_done) seen = 1'b1;
    end
    check({tag, "_done_seen"}, 64'(seen), 64'd1);
    got_err  = bus.o_err;
    got_code = bus.o_err_code;
    @(negedge clk);
    check({tag, "_done_1cyc"}, 64'(bus.o_done), 64'd0);
  endtask

  int d0;

  initial begin
    rst = 1'b1; clr = 1'b0;
    busy_polls = 0; busy_forever = 1'b0; final_status = 32'd0; resp_val = 32'h5;
    err_at = -1; mem_base = '0; done_cnt = 0; done_long = 0; done_prev = 1'b0;
    bus.i_req_valid = 1'b0; bus.i_req_write = 1'b0; bus.i_req_sector = 32'd0;
    bus.i_req_addr = '0; bus.i_req_nblk = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_ready", 64'(bus.o_req_ready), 64'd1);
    check("rst_done",  64'(bus.o_done), 64'd0);
    check("rst_err",   {61'd0, bus.o_err, bus.o_err_code}, 64'd0);
    check("rst_strb",  {bus.o_sd_cyc, bus.o_sd_stb, bus.o_sd_we, bus.o_mem_cyc, bus.o_mem_stb, bus.o_mem_we}, 64'd0);
    check("rst_addr",  {bus.o_sd_addr, bus.o_mem_addr}, 64'd0);
    check("rst_data",  {bus.o_sd_data, bus.o_mem_data}, 64'd0);
    rst = 1'b0;

    // single-sector read
    busy_polls = 3; final_status = 32'h0;
    start_req(1'b0, 32'h10, 28'h100, 8'd0);
    check("rd_ready_drop", 64'(bus.o_req_ready), 64'd0);
    wait_done("rd");
    check("rd_err", {61'd0, got_err, got_code}, 64'd0);
    check("rd_wr0", 64'(wr_log[0]), {29'd0, 3'd1, 32'h10});
    check("rd_wr1", 64'(wr_log[1]), {29'd0, 3'd0, 32'h8851});
    check("rd_wr2", 64'(wr_log[2]), {29'd0, 3'd0, 32'h0});
    check("rd_nwr", 64'(wr_n), 64'd3);
    check("rd_polls", 64'(status_reads), 64'd4);
    check("rd_fifo_rd", 64'(fifo_rd_cnt), 64'd128);
    check("rd_mem_wr", 64'(mem_wr_cnt), 64'd128);
    check("rd_mem_bad", 64'(mem_bad), 64'd0);
    check("rd_ready_back", 64'(bus.o_req_ready), 64'd1);
    check("rd_err_hold", {61'd0, bus.o_err, bus.o_err_code}, 64'd0);

    // three-sector write across the 32-bit sector wrap
    busy_polls = 1; resp_val = 32'h05;
    start_req(1'b1, 32'hFFFF_FFFF, 28'h200, 8'd2);
    wait_done("wr");
    check("wr_err", {61'd0, got_err, got_code}, 64'd0);
    check("wr_dat_n", 64'(dat_cnt), 64'd3);
    check("wr_dat0", 64'(dat_log[0]), 64'hFFFF_FFFF);
    check("wr_dat1", 64'(dat_log[1]), 64'h0);
    check("wr_dat2", 64'(dat_log[2]), 64'h1);
    check("wr_cmd", 64'(cmd_wr_cnt), 64'd3);
    check("wr_frst", 64'(frst_cnt), 64'd3);
    check("wr_mem_rd", 64'(mem_rd_cnt), 64'd384);
    check("wr_fifo_wr", 64'(fifo_wr_cnt), 64'd384);
    check("wr_fifo_bad", 64'(fifo_bad + mem_bad), 64'd0);
    check("wr_resp_n", 64'(resp_cnt), 64'd3);

    // bad data-token response stops after the first sector
    resp_val = 32'h0B;
    start_req(1'b1, 32'h40, 28'h400, 8'd2);
    wait_done("tok");
    check("tok_err", {61'd0, got_err, got_code}, {61'd0, 1'b1, 3'd2});
    check("tok_cmd", 64'(cmd_wr_cnt), 64'd1);
    check("tok_mem_rd", 64'(mem_rd_cnt), 64'd128);
    check("tok_err_hold", {61'd0, bus.o_err, bus.o_err_code}, {61'd0, 1'b1, 3'd2});

    // command error reported at the end of polling
    resp_val = 32'h05; busy_polls = 2; final_status = 32'h8000;
    start_req(1'b0, 32'h77, 28'h800, 8'd0);
    wait_done("cmd");
    check("cmd_err", {61'd0, got_err, got_code}, {61'd0, 1'b1, 3'd1});
    check("cmd_polls", 64'(status_reads), 64'd3);
    check("cmd_fifo_rd", 64'(fifo_rd_cnt), 64'd0);

    // memory bus error on word 50 of a read
    final_status = 32'h0; busy_polls = 0; err_at = 50;
    start_req(1'b0, 32'h5, 28'h900, 8'd0);
    wait_done("mem");
    check("mem_err", {61'd0, got_err, got_code}, {61'd0, 1'b1, 3'd3});
    check("mem_cyc_drop", 64'(err_next_cyc), 64'd0);
    check("mem_wr_n", 64'(mem_wr_cnt), 64'd50);
    check("mem_fifo_rd", 64'(fifo_rd_cnt), 64'd51);
    check("mem_no_sd", 64'(sd_after_err), 64'd0);
    err_at = -1;

`ifdef SDSPI_SEQ_TIMEOUT_EN
    // permanent busy trips the poll limit
    busy_forever = 1'b1;
    start_req(1'b0, 32'h9, 28'hA00, 8'd0);
    wait_done("to");
    check("to_err", {61'd0, got_err, got_code}, {61'd0, 1'b1, 3'd4});
    check("to_polls", 64'(status_reads), 64'd5);
    busy_forever = 1'b0;
`endif

    // reset while polling a permanently busy card
    busy_forever = 1'b1;
    d0 = done_cnt;
    start_req(1'b0, 32'h3, 28'hB00, 8'd0);
    for (int i = 0; i < 200 && status_reads < 2; i++) @(negedge clk);
    check("rst_mid_polling", 64'(status_reads >= 2), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_strb", {bus.o_sd_cyc, bus.o_sd_stb, bus.o_mem_cyc, bus.o_mem_stb}, 64'd0);
    check("rst_mid_ready", 64'(bus.o_req_ready), 64'd1);
    rst = 1'b0;
    busy_forever = 1'b0;
    repeat (10) @(negedge clk);
    check("rst_mid_nodone", 64'(done_cnt - d0), 64'd0);
    check("rst_mid_idle", {bus.o_sd_cyc, bus.o_req_ready}, 64'd1);
    check("done_width", 64'(done_long), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/sdspi_blk_seq.md
Name: sdspi_blk_seq

Overview:
- Block-transfer sequencer that drives the SD-SPI controller's 3-bit Wishbone register port as a bus master.
- Moves whole 512-byte sectors between the SD card and system memory through a second, classic Wishbone memory master.
- Offloads CMD17/CMD24 issue, busy polling, FIFO A streaming and error checking from the CPU; one request covers 1..256 consecutive sectors.

Parameters:
- MAW, 28, memory word-address width.
- POLL_LIMIT, 24'd16000000, status polls before timeout (only with SDSPI_SEQ_TIMEOUT_EN).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  synchronous active-high reset
- i_req_valid  in  1  request strobe
- o_req_ready  out  1  high in IDLE
- i_req_write  in  1  1 = memory->card (CMD24), 0 = card->memory (CMD17)
- i_req_sector  in  32  first sector argument
- i_req_addr  in  MAW  first memory word address
- i_req_nblk  in  8  sector count minus 1
- o_done  out  1  one-cycle completion pulse
- o_err  out  1  valid with o_done
- o_err_code  out  3  0 ok, 1 cmd error, 2 data-token error, 3 memory bus error, 4 timeout
- o_sd_cyc, o_sd_stb, o_sd_we  out  1 each  controller register master
- o_sd_addr  out  3  register address
- o_sd_data  out  32  write data
- i_sd_ack  in  1
- i_sd_data  in  32
- o_mem_cyc, o_mem_stb, o_mem_we  out  1 each  memory master, classic single transfer
- o_mem_addr  out  MAW
- o_mem_data  out  32
- o_mem_sel  out  4  always 4'hf
- i_mem_ack, i_mem_err  in  1 each
- i_mem_data  in  32

Behaviour:
- Reset: state IDLE; o_req_ready=1; o_done=0; o_err=0; o_err_code=0; all cyc/stb/we=0; address/data outputs=0.
- Handshake: request accepted when i_req_valid && o_req_ready. Sector, address and count are latched; o_req_ready drops the next cycle.
- Each register or memory access is one transaction:
  - cyc/stb asserted until the ack, then dropped for at least 1 cycle.
  - stb is never asserted while a previous ack is pending.
  - Read data is captured on the ack cycle.
- Read path, per sector:
  - ARG: write DAT (addr 1) = sector.
  - CMD: write CMD (addr 0) = 32'h8851 (clear err, use FIFO A, read, CMD17).
  - POLL: read addr 0 repeatedly until bit14 (busy) = 0. If bit15 (err) = 1, finish with code 1.
  - FRST: write addr 0 = 32'h0 to rewind the FIFO pointer.
  - 128 iterations of: FIFO_RD (read addr 2), then MEM_WR (write word to mem_addr, mem_addr+1).
- Write path, per sector:
  - FRST.
  - 128 iterations of: MEM_RD (read mem_addr, mem_addr+1), then FIFO_WR (write addr 2).
  - ARG, then CMD = 32'h8C58 (CMD24, write), then POLL.
  - RESP: read DAT. If (data[4:0] != 5'b00101) or bit15 was set, finish with code 2 (code 1 if bit15 was set).
- NEXT state:
  - If blocks_left == 0, go to DONE.
  - Otherwise sector += 1 (32-bit wrap allowed), blocks_left -= 1, and restart at ARG (read) or FRST (write).
- Word counter: 7 bits, wraps 127->0. Sector end is detected on the ack of word 127.
- i_mem_err terminates immediately with code 3: drop cyc, no further controller access. An in-flight SD command is left to the controller's own watchdog.
- DONE: o_done=1 for exactly 1 cycle along with o_err/o_err_code, then IDLE. o_err/o_err_code hold until the next acceptance.
- i_reset mid-operation: abort within 1 cycle with all strobes 0. No o_done pulse.
- i_req_valid is ignored outside IDLE.

Optional Feature:
- Macro SDSPI_SEQ_TIMEOUT_EN.
- Defined: a 24-bit poll counter loads POLL_LIMIT on entering POLL and decrements on each status read ack. At 0, finish with code 4.
- Undefined: POLL waits indefinitely; code 4 is never produced.

Test Plan:
- Read, nblk=0, sector 0x10, addr 0x100; controller model returns status 0x0000 after 3 busy polls. Required:
  - Register writes DAT=0x10, CMD=0x8851, CMD=0x0.
  - 128 FIFO reads.
  - Memory writes to 0x100..0x17F with matching data.
  - o_done=1, o_err=0.
- Write, nblk=2, sector 0xFFFFFFFF. Required:
  - 3 sectors sent with DAT values 0xFFFFFFFF, 0x0, 0x1.
  - 384 memory reads.
  - Each CMD = 0x8C58.
  - DAT response 0x05 gives o_err=0.
- Write with DAT response 0x0B -> o_done with o_err=1, code 2; no second sector.
- Read with status bit15 set at poll end -> code 1, zero FIFO reads.
- i_mem_err on word 50 of a read -> code 3, o_mem_cyc=0 the next cycle; i_reset mid-POLL -> all strobes 0 the next cycle, o_req_ready=1, no o_done.
- With SDSPI_SEQ_TIMEOUT_EN and POLL_LIMIT=5, busy held permanently -> code 4 after exactly 5 status reads.
